// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, 16x oversampled start validation, LSB-first deserialise, stop/parity check.
// Latency: pulse one clk after the mid-stop-bit tick; no backpressure, consumer must take rx_data on rx_valid.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int SAMPLE     = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en_sample,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);

  localparam int CW = $clog2(SAMPLE);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(SAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(SAMPLE - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || SAMPLE < 4 || (SAMPLE % 2) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx: illegal parameter set");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shift;
  logic                 rx_meta;
  logic                 rx_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_bad;
  assign par_bad = ((^shift) ^ par_bit) != PARITY_ODD[0];
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      // Pulses last one clk regardless of the tick rate.
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (en_sample) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state   <= START;
              cnt     <= '0;
              rx_busy <= 1'b1;
            end
          end
          START: begin
            if (cnt == HALF_CNT) begin
              if (rx_s) begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                state <= DATA;
                cnt   <= '0;
                idx   <= '0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (cnt == FULL_CNT) begin
              shift <= {rx_s, shift[DATA_BITS-1:1]};
              cnt   <= '0;
              idx   <= idx + 1'b1;
              if (idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (cnt == FULL_CNT) begin
              par_bit <= rx_s;
              cnt     <= '0;
              state   <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (cnt == FULL_CNT) begin
              // Leave at mid stop bit so an immediately following start edge is caught.
              state   <= IDLE;
              cnt     <= '0;
              rx_busy <= 1'b0;
              if (!rx_s) frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              if (par_bad) parity_err <= 1'b1;
              if (rx_s && !par_bad) begin
`else
              if (rx_s) begin
`endif
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 16 ticks per bit, one en_sample strobe every 4 clocks.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en_sample = 1'b0;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  int errors = 0;
  int checks = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int div = 0;
  logic [7:0] data_q[$];

`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  uart_rx #(.DATA_BITS(8), .SAMPLE(16), .PARITY_ODD(0)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en_sample (en_sample),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div = (div == 3) ? 0 : div + 1;
    en_sample = (div == 3);
  end

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid = n_valid + 1;
      data_q.push_back(rx_data);
    end
    if (frame_err) n_ferr = n_ferr + 1;
    if (parity_err) n_perr = n_perr + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    assert (got === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!en_sample) @(posedge clk);
    end
  endtask

  task automatic set_rx(input logic b);
    @(negedge clk);
    rx = b;
  endtask

  task automatic send_bit(input logic b);
    set_rx(b);
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pb);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(pb);
`else
    if (pb === 1'bx) send_bit(1'b1);
`endif
    send_bit(stop);
  endtask

  int v0, f0, p0;

  initial begin
    rx = 1'b1;
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_parity_err", parity_err, 1'b0);
    check("reset_rx_busy", rx_busy, 1'b0);
    reset_n = 1'b1;
    wait_ticks(4);

    // 0xA5, good stop
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    wait_ticks(4);
    @(negedge clk);
    check("a5_valid_count", n_valid - v0, 1);
    check("a5_rx_data", rx_data, 8'hA5);
    check("a5_frame_err", n_ferr - f0, 0);
    check("a5_busy_after", rx_busy, 1'b0);

    // 4-tick glitch is rejected as a false start
    v0 = n_valid; f0 = n_ferr;
    set_rx(1'b0);
    wait_ticks(4);
    @(negedge clk);
    check("glitch_busy_during", rx_busy, 1'b1);
    rx = 1'b1;
    wait_ticks(8);
    @(negedge clk);
    check("glitch_busy_after", rx_busy, 1'b0);
    wait_ticks(16);
    check("glitch_valid", n_valid - v0, 0);
    check("glitch_frame_err", n_ferr - f0, 0);

    // 0x3C with stop low
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    set_rx(1'b1);
    wait_ticks(24);
    @(negedge clk);
    check("ferr_pulse", n_ferr - f0, 1);
    check("ferr_no_valid", n_valid - v0, 0);
    check("ferr_data_held", rx_data, 8'hA5);

    // back-to-back 0x00, 0xFF
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    wait_ticks(8);
    @(negedge clk);
    check("b2b_valid_count", n_valid - v0, 2);
    check("b2b_first", (data_q.size() > v0) ? data_q[v0] : 8'hxx, 8'h00);
    check("b2b_second", (data_q.size() > v0 + 1) ? data_q[v0+1] : 8'hxx, 8'hFF);
    check("b2b_frame_err", n_ferr - f0, 0);

    // reset during data bit 4 of 0x55, then 0x81
    v0 = n_valid; f0 = n_ferr;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h55 >> i));
    set_rx(1'b1);
    wait_ticks(8);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("rst_mid_busy", rx_busy, 1'b0);
    check("rst_mid_data", rx_data, 8'h00);
    wait_ticks(40);
    send_frame(8'h81, 1'b1, ^8'h81);
    wait_ticks(8);
    @(negedge clk);
    check("rst_valid_count", n_valid - v0, 1);
    check("rst_rx_data", rx_data, 8'h81);
    check("rst_frame_err", n_ferr - f0, 0);

    // break: line low for one whole frame
    v0 = n_valid; f0 = n_ferr;
    set_rx(1'b0);
    wait_ticks(FRAME_BITS * 16);
    @(negedge clk);
    check("break_busy_restart", rx_busy, 1'b1);
    rx = 1'b1;
    wait_ticks(24);
    @(negedge clk);
    check("break_frame_err", n_ferr - f0, 1);
    check("break_no_valid", n_valid - v0, 0);
    check("break_busy_after", rx_busy, 1'b0);

`ifdef UART_RX_PARITY_EN
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h01, 1'b1, 1'b0);
    wait_ticks(8);
    @(negedge clk);
    check("par_bad_perr", n_perr - p0, 1);
    check("par_bad_no_valid", n_valid - v0, 0);
    check("par_bad_data_held", rx_data, 8'h81);
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h01, 1'b1, 1'b1);
    wait_ticks(8);
    @(negedge clk);
    check("par_ok_valid", n_valid - v0, 1);
    check("par_ok_data", rx_data, 8'h01);
    check("par_ok_perr", n_perr - p0, 0);
`else
    p0 = n_perr;
    wait_ticks(2);
    check("no_parity_err_ever", n_perr - p0 + n_perr, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
